shift_seq_ctrl: RTL

- Sequencer that drives the 8-bit universal shift register's ctrl/d inputs to serialise one parallel word.
- Flow: accept word via valid/ready → issue one load → issue exactly N shifts in the requested direction → present each exiting bit as a serial stream → pulse done.
- Sits between a word producer and the shift register; reads the register's q back to form the serial output.

---
 rtl/shift_seq_pkg.sv | 19 +
 rtl/shift_seq_ctrl_if.sv | 12 +
 rtl/shift_beat_counter.sv | 27 ++
 rtl/shift_seq_ctrl.sv | 112 +++++++++++
 4 files changed

// File: rtl/shift_seq_pkg.sv
// Shared types and encodings for the shift-register sequencer.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] CTRL_HOLD = 2'b00;
  localparam logic [1:0] CTRL_SHL  = 2'b01;
  localparam logic [1:0] CTRL_SHR  = 2'b10;
  localparam logic [1:0] CTRL_LOAD = 2'b11;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Word producer handshake into the shift sequencer.
interface shift_seq_ctrl_if #(
  parameter int unsigned N = 8
);
  logic         start_valid;
  logic         start_ready;
  logic [N-1:0] word;
  logic         dir;

  modport master (output start_valid, output word, output dir, input start_ready);
  modport slave  (input start_valid, input word, input dir, output start_ready);
endinterface

// File: rtl/shift_beat_counter.sv
// Mod-N shift beat counter with enable, synchronous clear and terminal-count flag.
module shift_beat_counter #(
  parameter int unsigned N     = 8,
  parameter int unsigned CNT_W = $clog2(N)
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tc
);

  logic [CNT_W-1:0] cnt;

  assign tc = (cnt == CNT_W'(N - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequencer that loads a word into the universal shift register and serialises it.
// SHIFT_SEQ_CTRL_ROTATE_EN: recirculate the exiting bit instead of using fill.
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  shift_seq_ctrl_if.slave      prod,
  input  logic                 fill,
  input  logic                 hold,
  input  logic [N-1:0]         q,
  output logic [1:0]           sr_ctrl,
  output logic [N-1:0]         sr_d,
  output logic                 ser_out,
  output logic                 ser_valid,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned CNT_W = $clog2(N);

  state_t       state;
  logic [N-1:0] word_lat;
  logic         dir_lat;
  logic         beat;
  logic         tc;
  logic         exit_bit;
  logic         in_bit;
  logic         unused_q_mid;

  assign unused_q_mid = ^q[N-2:1];
  assign beat         = (state == SHIFT) && !hold;

  shift_beat_counter #(
    .N     (N),
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (beat),
    .clr   (state == LOAD),
    .tc    (tc)
  );

  // Word and direction are captured only on the IDLE handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      word_lat <= '0;
      dir_lat  <= DIR_LEFT;
    end else begin
      case (state)
        IDLE: begin
          if (prod.start_valid) begin
            word_lat <= prod.word;
            dir_lat  <= prod.dir;
            state    <= LOAD;
          end
        end
        LOAD:    state <= SHIFT;
        SHIFT:   if (beat && tc) state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign prod.start_ready = (state == IDLE);
  assign exit_bit         = (dir_lat == DIR_LEFT) ? q[N-1] : q[0];

`ifdef SHIFT_SEQ_CTRL_ROTATE_EN
  logic unused_fill;
  assign unused_fill = fill;
  assign in_bit      = exit_bit;
`else
  assign in_bit      = fill;
`endif

  // Register-side controls decode from state; ser_out taps q before the shift lands.
  always_comb begin
    sr_ctrl   = CTRL_HOLD;
    sr_d      = '0;
    ser_out   = 1'b0;
    ser_valid = 1'b0;
    busy      = (state != IDLE);
    done      = 1'b0;
    case (state)
      LOAD: begin
        sr_ctrl = CTRL_LOAD;
        sr_d    = word_lat;
      end
      SHIFT: begin
        if (!hold) begin
          ser_valid = 1'b1;
          ser_out   = exit_bit;
          if (dir_lat == DIR_LEFT) begin
            sr_ctrl = CTRL_SHL;
            sr_d[0] = in_bit;
          end else begin
            sr_ctrl   = CTRL_SHR;
            sr_d[N-1] = in_bit;
          end
        end
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule
